// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between two refill requesters; one burst in flight.
// Accept -> arvalid is 1 cycle; R beats pass through with zero latency and no requester backpressure.
module axi_rd_arbiter #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [ADDR_WIDTH-1:0]     req0_addr,
  input  logic [7:0]                req0_len,
  input  logic [2:0]                req0_size,
  input  logic [ADDR_WIDTH-1:0]     req1_addr,
  input  logic [7:0]                req1_len,
  input  logic [2:0]                req1_size,
  output logic [1:0]                resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] resp_data,
  output logic                      resp_last,
  output logic                      resp_err,
  output logic [3:0]                arid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [3:0]            arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_acc_q, err_acc_d;

  logic gnt_vld;
  logic gnt_idx;
  logic beat_err;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = 1'b0;
    case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign beat_err = (rresp != 2'b00) || (rid != arid_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    beat_cnt_d   = beat_cnt_q;
    err_acc_d    = err_acc_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d      = ADDR;
          last_grant_d = gnt_idx;
          arid_d       = {3'b000, gnt_idx};
          araddr_d     = gnt_idx ? req1_addr : req0_addr;
          arlen_d      = gnt_idx ? req1_len  : req0_len;
          arsize_d     = gnt_idx ? req1_size : req0_size;
          beat_cnt_d   = 8'd0;
          err_acc_d    = 1'b0;
        end
      end
      ADDR: begin
        if (arready) state_d = DATA;
      end
      DATA: begin
        if (rvalid) begin
          beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
          err_acc_d  = err_acc_q | beat_err;
          if (rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      arid_q       <= 4'd0;
      araddr_q     <= '0;
      arlen_q      <= 8'd0;
      arsize_q     <= 3'd0;
      beat_cnt_q   <= 8'd0;
      err_acc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      beat_cnt_q   <= beat_cnt_d;
      err_acc_q    <= err_acc_d;
    end
  end

  // Beat count mismatch on rlast catches both early and late termination.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    if (state_q == IDLE && gnt_vld) req_ready = gnt_idx ? 2'b10 : 2'b01;
    if (state_q == DATA && rvalid) begin
      resp_valid = arid_q[0] ? 2'b10 : 2'b01;
      resp_last  = rlast;
      resp_err   = rlast & (err_acc_q | beat_err | (beat_cnt_q != arlen_q));
    end
  end

  assign resp_data = rdata;
  assign arid      = arid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = 2'b01;
  assign arvalid   = (state_q == ADDR);
  assign rready    = (state_q == DATA);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, address hold, beat steering, error flagging, reset.
module tb_axi_rd_arbiter;

  localparam logic [127:0] BEAT_BASE = 128'hA5A5_0000_1111_2222_3333_4444_5555_0000;

  logic         aclk;
  logic         aresetn;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [31:0]  req0_addr, req1_addr;
  logic [7:0]   req0_len, req1_len;
  logic [2:0]   req0_size, req1_size;
  logic [1:0]   resp_valid;
  logic [127:0] resp_data;
  logic         resp_last, resp_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int n_cmp;
  int n_err;

  axi_rd_arbiter #(.AXI_DATA_WIDTH(128), .ADDR_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_size(req0_size),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_size(req1_size),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drives n beats; rlast on beat last_at, rresp=SLVERR on beat bad (0 = none).
  task automatic beats(input int n, input int last_at, input logic [3:0] id, input int bad,
                       input logic [1:0] ev, input logic eerr);
    for (int i = 1; i <= n; i++) begin
      rvalid = 1'b1;
      rid    = id;
      rresp  = (i == bad) ? 2'b10 : 2'b00;
      rlast  = (i == last_at);
      rdata  = BEAT_BASE | 128'(i);
      settle();
      chk("beat_valid", 128'(resp_valid), 128'(ev));
      chk("beat_data", resp_data, BEAT_BASE | 128'(i));
      chk("beat_last", 128'(resp_last), 128'(i == last_at));
      chk("beat_err", 128'(resp_err), 128'((i == last_at) ? eerr : 1'b0));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    aresetn = 1'b0; req_valid = 2'b00; arready = 1'b0;
    req0_addr = 32'h0; req0_len = 8'd0; req0_size = 3'd0;
    req1_addr = 32'h0; req1_len = 8'd0; req1_size = 3'd0;
    rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    #3;
    chk("rst_arvalid", 128'(arvalid), 128'(1'b0));
    chk("rst_rready", 128'(rready), 128'(1'b0));
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_resp_valid", 128'(resp_valid), 128'(2'b00));
    chk("rst_araddr", 128'(araddr), 128'(32'h0));
    chk("rst_arid", 128'(arid), 128'(4'd0));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    #1;

    // Both requesters from reset: requester 0 first, then 1.
    req0_addr = 32'h1000_0000; req0_len = 8'd3; req0_size = 3'd4;
    req1_addr = 32'h2000_0040; req1_len = 8'd3; req1_size = 3'd3;
    req_valid = 2'b11; arready = 1'b1;
    settle();
    chk("tie_first", 128'(req_ready), 128'(2'b01));
    tick();
    chk("addr_no_ready", 128'(req_ready), 128'(2'b00));
    chk("t2_arvalid", 128'(arvalid), 128'(1'b1));
    chk("t2_arid0", 128'(arid), 128'(4'd0));
    chk("t2_araddr0", 128'(araddr), 128'(32'h1000_0000));
    chk("t2_arlen0", 128'(arlen), 128'(8'd3));
    tick();
    chk("t2_rready", 128'(rready), 128'(1'b1));
    chk("t2_arvalid_drop", 128'(arvalid), 128'(1'b0));
    chk("data_no_ready", 128'(req_ready), 128'(2'b00));
    beats(4, 4, 4'd0, 0, 2'b01, 1'b0);
    settle();
    chk("tie_second", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid = 2'b00;
    chk("t2_arid1", 128'(arid), 128'(4'd1));
    chk("t2_araddr1", 128'(araddr), 128'(32'h2000_0040));
    chk("t2_arsize1", 128'(arsize), 128'(3'd3));
    tick();
    beats(4, 4, 4'd1, 0, 2'b10, 1'b0);

    // Alternation back to requester 0, with arready stalled 3 cycles.
    req_valid = 2'b11; arready = 1'b0;
    settle();
    chk("tie_alt", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) arready = 1'b1;
      settle();
      chk("stall_arvalid", 128'(arvalid), 128'(1'b1));
      chk("stall_araddr", 128'(araddr), 128'(32'h1000_0000));
      chk("stall_req_ready", 128'(req_ready), 128'(2'b00));
      tick();
    end
    chk("stall_rready", 128'(rready), 128'(1'b1));
    // SLVERR on beat 2: error reported only on last beat.
    beats(4, 4, 4'd0, 2, 2'b01, 1'b1);

    // Single-beat transaction from requester 0, clean response.
    req0_addr = 32'h1C00_0000; req0_len = 8'd0; req0_size = 3'd4;
    req_valid = 2'b01;
    settle();
    chk("t1_req_ready", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("t1_arvalid", 128'(arvalid), 128'(1'b1));
    chk("t1_arid", 128'(arid), 128'(4'd0));
    chk("t1_araddr", 128'(araddr), 128'(32'h1C00_0000));
    chk("t1_arlen", 128'(arlen), 128'(8'd0));
    chk("t1_arsize", 128'(arsize), 128'(3'd4));
    chk("t1_arburst", 128'(arburst), 128'(2'b01));
    tick();
    beats(1, 1, 4'd0, 0, 2'b01, 1'b0);
    settle();
    chk("t1_idle_rready", 128'(rready), 128'(1'b0));
    chk("t1_idle_resp", 128'(resp_valid), 128'(2'b00));

    // Early rlast: len 3 but rlast on beat 2.
    req1_len = 8'd3;
    req_valid = 2'b10;
    settle();
    chk("early_req_ready", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid = 2'b00;
    tick();
    beats(2, 2, 4'd1, 0, 2'b10, 1'b1);
    settle();
    chk("early_idle_rready", 128'(rready), 128'(1'b0));
    req_valid = 2'b01;
    settle();
    chk("after_early_ready", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = 2'b00;
    tick();
    beats(1, 1, 4'd0, 0, 2'b01, 1'b0);

    // Reset during a requester 0 burst; last_grant must return to 1.
    req0_len = 8'd3;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    rvalid = 1'b1; rid = 4'd0; rlast = 1'b0; rdata = BEAT_BASE;
    settle();
    chk("pre_rst_resp", 128'(resp_valid), 128'(2'b01));
    aresetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", 128'(arvalid), 128'(1'b0));
    chk("mid_rst_rready", 128'(rready), 128'(1'b0));
    chk("mid_rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("mid_rst_resp", 128'(resp_valid), 128'(2'b00));
    rvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    req0_len = 8'd0;
    req_valid = 2'b11;
    settle();
    chk("post_rst_tie", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("post_rst_arvalid", 128'(arvalid), 128'(1'b1));
    chk("post_rst_arid", 128'(arid), 128'(4'd0));
    tick();
    beats(1, 1, 4'd0, 0, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
